// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter with address decode and one-cycle read-data return.
// M0 is the park owner; an optional hold limit forces hand-over under contention.
module bus_arbiter #(
  parameter int unsigned HOLD_LIMIT = 0,
  parameter logic [2:0]  S0_BASE    = 3'b000,
  parameter logic [2:0]  S1_BASE    = 3'b001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M0_req,
  input  logic        M0_wr,
  input  logic [7:0]  M0_address,
  input  logic [31:0] M0_dout,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  input  logic [31:0] S0_dout,
  input  logic [31:0] S1_dout,
  output logic        M0_grant,
  output logic        M1_grant,
  output logic [7:0]  S_address,
  output logic [31:0] S_din,
  output logic        S_wr,
  output logic        S0_sel,
  output logic        S1_sel,
  output logic [31:0] M_din
);

  typedef enum logic {GRANT_M0, GRANT_M1} state_e;

  localparam logic [7:0] HoldLast = (HOLD_LIMIT == 0) ? 8'd0 : 8'(HOLD_LIMIT - 1);

  state_e      state_q, state_d;
  logic        m0Grant_q, m1Grant_q;
  logic [7:0]  holdCnt_q, holdCnt_d;
  logic [1:0]  rsel_q, rsel_d;
  logic        ownerReq, otherReq, holdExpired;

  assign ownerReq    = m1Grant_q ? M1_req : M0_req;
  assign otherReq    = m1Grant_q ? M0_req : M1_req;
  assign holdExpired = (HOLD_LIMIT != 0) && ownerReq && otherReq && (holdCnt_q == HoldLast);

  // Releasing M1 always parks on M0, even when M0 is idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GRANT_M0: if ((!M0_req && M1_req) || holdExpired) state_d = GRANT_M1;
      GRANT_M1: if (!M1_req || holdExpired) state_d = GRANT_M0;
      default:  state_d = GRANT_M0;
    endcase

    holdCnt_d = 8'd0;
    if (state_d == state_q && otherReq && holdCnt_q != 8'hFF) begin
      holdCnt_d = holdCnt_q + 8'd1;
    end else if (state_d == state_q && otherReq) begin
      holdCnt_d = holdCnt_q;
    end
  end

  assign S_address = m1Grant_q ? M1_address : M0_address;
  assign S_din     = m1Grant_q ? M1_dout    : M0_dout;
  assign S_wr      = m1Grant_q ? M1_wr      : M0_wr;
  assign S0_sel    = ownerReq && (S_address[7:5] == S0_BASE);
  assign S1_sel    = ownerReq && (S_address[7:5] == S1_BASE);
  assign rsel_d    = {S1_sel & ~S_wr, S0_sel & ~S_wr};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= GRANT_M0;
      m0Grant_q <= 1'b1;
      m1Grant_q <= 1'b0;
      holdCnt_q <= 8'd0;
      rsel_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      m0Grant_q <= (state_d == GRANT_M0);
      m1Grant_q <= (state_d == GRANT_M1);
      holdCnt_q <= holdCnt_d;
      rsel_q    <= rsel_d;
    end
  end

  // Read data follows the select captured in the address cycle, not the current owner.
  always_comb begin
    M_din = 32'h0;
    case (rsel_q)
      2'b01:   M_din = S0_dout;
      2'b10:   M_din = S1_dout;
      default: M_din = 32'h0;
    endcase
  end

  assign M0_grant = m0Grant_q;
  assign M1_grant = m1Grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a directed vector table, hand-written multi-cycle sequences,
// and randomized traffic against an ownership/streak model for unlimited and 4-cycle hold.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0Req = 1'b0, m0Wr = 1'b0, m1Req = 1'b0, m1Wr = 1'b0;
  logic [7:0]  m0Address = 8'h0, m1Address = 8'h0;
  logic [31:0] m0Dout = 32'h0, m1Dout = 32'h0, s0Dout = 32'h0, s1Dout = 32'h0;

  logic        g0 [2];
  logic        g1 [2];
  logic [7:0]  sAddr [2];
  logic [31:0] sDin [2];
  logic        sWr [2];
  logic        sel0 [2];
  logic        sel1 [2];
  logic [31:0] mDin [2];

  int checks = 0;
  int failures = 0;

  int mOwner [2] = '{0, 0};
  int mStreak [2] = '{0, 0};
  int mRsel [2] = '{0, 0};

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_LIMIT(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .M0_req(m0Req), .M0_wr(m0Wr), .M0_address(m0Address), .M0_dout(m0Dout),
    .M1_req(m1Req), .M1_wr(m1Wr), .M1_address(m1Address), .M1_dout(m1Dout),
    .S0_dout(s0Dout), .S1_dout(s1Dout),
    .M0_grant(g0[0]), .M1_grant(g1[0]), .S_address(sAddr[0]), .S_din(sDin[0]),
    .S_wr(sWr[0]), .S0_sel(sel0[0]), .S1_sel(sel1[0]), .M_din(mDin[0])
  );

  bus_arbiter #(.HOLD_LIMIT(4)) u4 (
    .clk(clk), .reset_n(reset_n),
    .M0_req(m0Req), .M0_wr(m0Wr), .M0_address(m0Address), .M0_dout(m0Dout),
    .M1_req(m1Req), .M1_wr(m1Wr), .M1_address(m1Address), .M1_dout(m1Dout),
    .S0_dout(s0Dout), .S1_dout(s1Dout),
    .M0_grant(g0[1]), .M1_grant(g1[1]), .S_address(sAddr[1]), .S_din(sDin[1]),
    .S_wr(sWr[1]), .S0_sel(sel0[1]), .S1_sel(sel1[1]), .M_din(mDin[1])
  );

  typedef struct {
    logic        req0, wr0;
    logic [7:0]  addr0;
    logic [31:0] dout0;
    logic        req1, wr1;
    logic [7:0]  addr1;
    logic [31:0] dout1;
    logic [31:0] s0, s1;
    logic        eG0, eG1;
    logic [7:0]  eAddr;
    logic [31:0] eDin;
    logic        eWr, eSel0, eSel1;
    logic [31:0] eMDin;
  } vec_t;

  vec_t vecs [10];

  function automatic int holdLimit(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [31:0] d1,
                               input logic [31:0] sd0, input logic [31:0] sd1);
    reset_n = rn;
    m0Req = r0; m0Wr = w0; m0Address = a0; m0Dout = d0;
    m1Req = r1; m1Wr = w1; m1Address = a1; m1Dout = d1;
    s0Dout = sd0; s1Dout = sd1;
  endtask

  // Ownership model: who holds the bus, how many contested cycles in a row, which slave a read hit.
  task automatic modelUpdate();
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mOwner[i] = 0; mStreak[i] = 0; mRsel[i] = 0;
      end else begin
        bit ownReq, othReq, wr, handOver;
        int region;
        ownReq = (mOwner[i] == 1) ? m1Req : m0Req;
        othReq = (mOwner[i] == 1) ? m0Req : m1Req;
        wr     = (mOwner[i] == 1) ? m1Wr : m0Wr;
        region = ((mOwner[i] == 1) ? int'(m1Address) : int'(m0Address)) / 32;
        mRsel[i] = (ownReq && !wr && region == 0) ? 1 : (ownReq && !wr && region == 1) ? 2 : 0;
        handOver = (mOwner[i] == 1 && !ownReq) || (othReq && !ownReq) ||
                   (holdLimit(i) != 0 && ownReq && othReq && mStreak[i] + 1 == holdLimit(i));
        if (handOver) begin
          mOwner[i] = 1 - mOwner[i];
          mStreak[i] = 0;
        end else if (othReq) begin
          mStreak[i] = (mStreak[i] >= 255) ? 255 : mStreak[i] + 1;
        end else begin
          mStreak[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic checkAgainstModel(input int i);
    bit own1, ownReq;
    logic [7:0] a;
    string p;
    own1   = (mOwner[i] == 1);
    ownReq = own1 ? m1Req : m0Req;
    a      = own1 ? m1Address : m0Address;
    p      = (i == 0) ? "u0" : "u4";
    checkOutput({p, ".M0_grant"}, 32'(g0[i]), 32'(!own1));
    checkOutput({p, ".M1_grant"}, 32'(g1[i]), 32'(own1));
    checkOutput({p, ".S_address"}, 32'(sAddr[i]), 32'(a));
    checkOutput({p, ".S_din"}, sDin[i], own1 ? m1Dout : m0Dout);
    checkOutput({p, ".S_wr"}, 32'(sWr[i]), 32'(own1 ? m1Wr : m0Wr));
    checkOutput({p, ".S0_sel"}, 32'(sel0[i]), 32'(ownReq && (int'(a) / 32 == 0)));
    checkOutput({p, ".S1_sel"}, 32'(sel1[i]), 32'(ownReq && (int'(a) / 32 == 1)));
    checkOutput({p, ".M_din"}, mDin[i], (mRsel[i] == 1) ? s0Dout : (mRsel[i] == 2) ? s1Dout : 32'h0);
  endtask

  initial begin
    vecs[0] = '{1,1,8'h05,32'hDEADBEEF, 0,0,8'h00,32'h0, 32'h0,32'h0,          1,0,8'h05,32'hDEADBEEF,1,1,0,32'h0};
    vecs[1] = '{0,0,8'h05,32'h0,        1,0,8'h21,32'h0, 32'h0,32'h12345678,   1,0,8'h05,32'h0,0,0,0,32'h0};
    vecs[2] = '{0,0,8'h05,32'h0,        1,0,8'h21,32'h0, 32'h0,32'h12345678,   0,1,8'h21,32'h0,0,0,1,32'h0};
    vecs[3] = '{1,0,8'h80,32'h0,        0,0,8'h21,32'h0, 32'h0,32'h12345678,   0,1,8'h21,32'h0,0,0,0,32'h12345678};
    vecs[4] = '{1,0,8'h80,32'h0,        0,0,8'h21,32'h0, 32'hAAAA5555,32'h12345678, 1,0,8'h80,32'h0,0,0,0,32'h0};
    vecs[5] = '{1,1,8'hC0,32'h11112222, 0,0,8'h21,32'h0, 32'hAAAA5555,32'h12345678, 1,0,8'hC0,32'h11112222,1,0,0,32'h0};
    vecs[6] = '{0,0,8'h10,32'h0,        0,0,8'h21,32'h0, 32'hAAAA5555,32'h12345678, 1,0,8'h10,32'h0,0,0,0,32'h0};
    vecs[7] = '{0,0,8'h10,32'h0,        0,0,8'h21,32'h0, 32'hAAAA5555,32'h12345678, 1,0,8'h10,32'h0,0,0,0,32'h0};
    vecs[8] = '{1,0,8'h10,32'h0,        0,0,8'h21,32'h0, 32'hCAFEF00D,32'h12345678, 1,0,8'h10,32'h0,0,1,0,32'h0};
    vecs[9] = '{0,0,8'h10,32'h0,        0,0,8'h21,32'h0, 32'hCAFEF00D,32'h12345678, 1,0,8'h10,32'h0,0,0,0,32'hCAFEF00D};

    // Reset state on both instances.
    #1;
    applyStimulus(0, 0,0,8'h0,32'h0, 0,0,8'h0,32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    tick();
    #4;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset.M0_grant", 32'(g0[i]), 32'd1);
      checkOutput("reset.M1_grant", 32'(g1[i]), 32'd0);
      checkOutput("reset.M_din", mDin[i], 32'h0);
    end
    tick();

    // Directed table on the unlimited-hold instance.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(1, vecs[v].req0, vecs[v].wr0, vecs[v].addr0, vecs[v].dout0,
                    vecs[v].req1, vecs[v].wr1, vecs[v].addr1, vecs[v].dout1, vecs[v].s0, vecs[v].s1);
      #4;
      checkOutput($sformatf("vec%0d.M0_grant", v), 32'(g0[0]), 32'(vecs[v].eG0));
      checkOutput($sformatf("vec%0d.M1_grant", v), 32'(g1[0]), 32'(vecs[v].eG1));
      checkOutput($sformatf("vec%0d.S_address", v), 32'(sAddr[0]), 32'(vecs[v].eAddr));
      checkOutput($sformatf("vec%0d.S_din", v), sDin[0], vecs[v].eDin);
      checkOutput($sformatf("vec%0d.S_wr", v), 32'(sWr[0]), 32'(vecs[v].eWr));
      checkOutput($sformatf("vec%0d.S0_sel", v), 32'(sel0[0]), 32'(vecs[v].eSel0));
      checkOutput($sformatf("vec%0d.S1_sel", v), 32'(sel1[0]), 32'(vecs[v].eSel1));
      checkOutput($sformatf("vec%0d.M_din", v), mDin[0], vecs[v].eMDin);
      tick();
    end

    // Reset pulsed while M1 owns the bus with read data in flight.
    applyStimulus(1, 0,0,8'h10,32'h0, 1,0,8'h22,32'h0, 32'h0, 32'h55AA55AA);
    tick();
    tick();
    #4;
    checkOutput("midread.M1_grant", 32'(g1[0]), 32'd1);
    checkOutput("midread.M_din", mDin[0], 32'h55AA55AA);
    reset_n = 1'b0;
    tick();
    #4;
    checkOutput("rstmid.M0_grant", 32'(g0[0]), 32'd1);
    checkOutput("rstmid.M1_grant", 32'(g1[0]), 32'd0);
    checkOutput("rstmid.M_din", mDin[0], 32'h0);
    tick();

    // Continuous contention from reset: u4 alternates every 4 cycles, u0 never lets go.
    applyStimulus(1, 1,0,8'h00,32'h0, 1,0,8'h20,32'h0, 32'h1, 32'h2);
    for (int n = 1; n <= 16; n++) begin
      #4;
      checkOutput($sformatf("hold%0d.u4.M0_grant", n), 32'(g0[1]), 32'(((n - 1) / 4) % 2 == 0));
      checkOutput($sformatf("hold%0d.u4.M1_grant", n), 32'(g1[1]), 32'(((n - 1) / 4) % 2 == 1));
      checkOutput($sformatf("hold%0d.u0.M0_grant", n), 32'(g0[0]), 32'd1);
      tick();
    end

    // Randomized traffic against the model, both instances.
    reset_n = 1'b0;
    tick();
    for (int c = 0; c < 400; c++) begin
      logic [7:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
      a1 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 39) != 0,
                    $urandom_range(0, 3) != 0, 1'($urandom), a0, $urandom,
                    $urandom_range(0, 2) != 0, 1'($urandom), a1, $urandom,
                    $urandom, $urandom);
      #4;
      checkAgainstModel(0);
      checkAgainstModel(1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
